serial_borrow_subtractor: RTL and testbench

Multi-cycle, bit-serial ripple-borrow subtractor computing `diff = a - b - b_in` one bit per clock, LSB first. It is the subtraction counterpart to the combinational ripple-carry adder in the arithmetic library. It is used where area matters more than latency, and is wrapped in a valid/ready handshake on both input and output. It sits between an operand producer and a result consumer in the datapath.

---
 rtl/serial_borrow_subtractor_if.sv | 36 +++
 rtl/serial_borrow_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_borrow_subtractor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_borrow_subtractor_if.sv
// Operand/result handshake bundle for serial_borrow_subtractor.
// The ovf signal exists only when SUB_SIGNED_OVF_EN is defined.
interface serial_borrow_subtractor_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] b;
    logic                  b_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] diff;
    logic                  b_out;
`ifdef SUB_SIGNED_OVF_EN
    logic                  ovf;
`endif

    // Producer/consumer side
    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, diff, b_out
`ifdef SUB_SIGNED_OVF_EN
        , input ovf
`endif
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, diff, b_out
`ifdef SUB_SIGNED_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor, diff = a - b - b_in, LSB first, one bit per clock.
// Optional signed overflow flag enabled by defining SUB_SIGNED_OVF_EN.
module serial_borrow_subtractor #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    serial_borrow_subtractor_if.slave bus
);
    localparam int CW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] a_sh_q, a_sh_d;
    logic [ADDR_WIDTH-1:0] b_sh_q, b_sh_d;
    logic [ADDR_WIDTH-1:0] diff_q, diff_d;
    logic                  borrow_q, borrow_d;
    logic [CW-1:0]         cnt_q, cnt_d;
`ifdef SUB_SIGNED_OVF_EN
    logic                  a_msb_q, a_msb_d;
    logic                  b_msb_q, b_msb_d;
    logic                  ovf_q, ovf_d;
`endif

    logic x, y, d_bit, borrow_nxt, last_bit;

    assign x          = a_sh_q[0];
    assign y          = b_sh_q[0];
    assign d_bit      = x ^ y ^ borrow_q;
    assign borrow_nxt = (~x & y) | (~(x ^ y) & borrow_q);
    assign last_bit   = (cnt_q == CW'(ADDR_WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last_bit)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode the state only
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Datapath next-state
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
`ifdef SUB_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_sh_d   = bus.a;
                b_sh_d   = bus.b;
                borrow_d = bus.b_in;
                cnt_d    = '0;
`ifdef SUB_SIGNED_OVF_EN
                a_msb_d  = bus.a[ADDR_WIDTH-1];
                b_msb_d  = bus.b[ADDR_WIDTH-1];
`endif
            end
            RUN: begin
                diff_d   = {d_bit, diff_q[ADDR_WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + CW'(1);
`ifdef SUB_SIGNED_OVF_EN
                // d_bit of the final step is the result MSB
                if (last_bit) ovf_d = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Borrow is frozen outside RUN, so it doubles as the held borrow-out
    assign bus.diff  = diff_q;
    assign bus.b_out = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor: directed cases, backpressure,
// mid-operation reset and 1000 back-to-back random operations.
module tb_serial_borrow_subtractor;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_borrow_subtractor_if #(.ADDR_WIDTH(W)) bus ();

    serial_borrow_subtractor #(.ADDR_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   b2b   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width unsigned subtraction; sign-rule overflow
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bi, input int acc);
        exp_t e;
        logic [W:0] full;
        full  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.d   = full[W-1:0];
        e.bo  = full[W];
        e.ov  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        e.acc = acc;
        return e;
    endfunction

    // Monitor / scoreboard
    bit   prev_ov  = 1'b0;
    bit   prev_b2b = 1'b0;
    int   last_hs  = -1;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_ov = 1'b0;
        end else begin
            if (b2b && !prev_b2b) last_hs = -1;
            prev_b2b = b2b;
            if (bus.out_valid && !prev_ov) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out_valid: got diff=%h with no pending operation", bus.diff);
                end else if (cyc - q[0].acc != W + 1) begin
                    bad++;
                    $display("FAIL latency: got %0d cycles expected %0d", cyc - q[0].acc - 1, W);
                end
            end
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                e = q.pop_front();
                total++;
                if (bus.diff !== e.d || bus.b_out !== e.bo) begin
                    bad++;
                    $display("FAIL result: got diff=%h b_out=%b expected diff=%h b_out=%b",
                             bus.diff, bus.b_out, e.d, e.bo);
                end
`ifdef SUB_SIGNED_OVF_EN
                total++;
                if (bus.ovf !== e.ov) begin
                    bad++;
                    $display("FAIL ovf: got %b expected %b (diff=%h)", bus.ovf, e.ov, e.d);
                end
`endif
                if (b2b && last_hs >= 0) begin
                    total++;
                    if (cyc - last_hs != W + 2) begin
                        bad++;
                        $display("FAIL interval: got %0d expected %0d", cyc - last_hs, W + 2);
                    end
                end
                last_hs = cyc;
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.b_in, cyc));
            prev_ov = bus.out_valid;
        end
    end

    // Present operands, hold until accepted; returns 1 time unit after the acceptance edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int n;
        bus.a = a; bus.b = b; bus.b_in = bi; bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [W-1:0] da [6] = '{16'h0005, 16'h0000, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF};
    logic [W-1:0] db [6] = '{16'h0003, 16'h0001, 16'h1233, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic         dbi[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        exp_t bp;
        int n;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", W'(bus.in_ready), W'(1));
        chk("reset_out_valid", W'(bus.out_valid), W'(0));
        chk("reset_diff", bus.diff, '0);
        chk("reset_b_out", W'(bus.b_out), W'(0));
`ifdef SUB_SIGNED_OVF_EN
        chk("reset_ovf", W'(bus.ovf), W'(0));
`endif
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            send(da[i], db[i], dbi[i]);
            bus.in_valid = 1'b0;
            drain();
        end

        // Backpressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        send(16'h9ABC, 16'h1234, 1'b1);
        bus.in_valid = 1'b0;
        bp = model(16'h9ABC, 16'h1234, 1'b1, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 40);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", W'(bus.out_valid), W'(1));
            chk("bp_diff", bus.diff, bp.d);
            chk("bp_b_out", W'(bus.b_out), W'(bp.bo));
            chk("bp_in_ready", W'(bus.in_ready), W'(0));
            @(posedge clk); #1;
            if (k == 1) begin
                bus.a = 16'h4444; bus.b = 16'h0101; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();

        // Reset at bit 7 aborts the operation
        send(16'h1111, 16'h2222, 1'b0);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", W'(bus.in_ready), W'(1));
        chk("abort_out_valid", W'(bus.out_valid), W'(0));
        repeat (20) @(posedge clk);
        #1;
        send(16'h00FF, 16'h000F, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // Back-to-back random traffic
        b2b = 1'b1;
        for (int i = 0; i < 1000; i++)
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        bus.in_valid = 1'b0;
        drain();
        b2b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
